// File: rtl/wb_bus_if_pkg.sv
// Shared types and constants for the Wishbone classic master bridge.
package wb_bus_if_pkg;

    typedef enum logic [1:0] {
        WB_IDLE           = 2'b00,
        WB_BUSY           = 2'b01,
        WB_WAIT_FOR_STALL = 2'b10
    } wb_state_e;

    localparam logic [31:0] ZERO_WORD    = 32'h0000_0000;
    localparam logic        RST_ENABLE_N = 1'b0;
    localparam int unsigned CNT_W        = 16;

    // Last counter value before abort; only meaningful when timeout is non-zero.
    function automatic logic [CNT_W-1:0] timeout_limit(input int unsigned timeout);
        logic [31:0] lim;
        lim = timeout - 32'd1;
        return lim[CNT_W-1:0];
    endfunction

endpackage

// File: rtl/wb_timeout_cnt.sv
// Saturating wait-for-ack counter with an expiry flag for the bus bridge.
module wb_timeout_cnt
    import wb_bus_if_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam logic [CNT_W-1:0] LIMIT   = timeout_limit(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear wins, otherwise count up and stick at all-ones.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = {CNT_W{1'b0}};
        end else if (en_i && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CNT_ONE;
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE_N) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (TIMEOUT != 32'd0) && (cnt_q == LIMIT);

endmodule

// File: rtl/wb_bus_if.sv
// Wishbone B3 classic master bridge: turns single-cycle CPU requests into
// cyc/stb transactions and stalls the pipeline until the slave acknowledges.
module wb_bus_if
    import wb_bus_if_pkg::*;
#(
    parameter int          DW      = 32,
    parameter int          AW      = 32,
    parameter int          STALL_W = 6,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall_i,
    input  logic               flush_i,
    input  logic               cpu_ce_i,
    input  logic               cpu_we_i,
    input  logic [AW-1:0]      cpu_addr_i,
    input  logic [DW/8-1:0]    cpu_sel_i,
    input  logic [DW-1:0]      cpu_data_i,
    output logic [DW-1:0]      cpu_data_o,
    output logic               stallreq_o,
    output logic               bus_err_o,
    input  logic [DW-1:0]      wishbone_data_i,
    input  logic               wishbone_ack_i,
    output logic [AW-1:0]      wishbone_addr_o,
    output logic [DW-1:0]      wishbone_data_o,
    output logic               wishbone_we_o,
    output logic [DW/8-1:0]    wishbone_sel_o,
    output logic               wishbone_stb_o,
    output logic               wishbone_cyc_o
);

    localparam int SW = DW / 8;

    wb_state_e         state_q, state_d;
    logic [AW-1:0]     addr_q, addr_d;
    logic [DW-1:0]     wdata_q, wdata_d;
    logic [DW-1:0]     rd_buf_q, rd_buf_d;
    logic [SW-1:0]     sel_q, sel_d;
    logic              we_q, we_d;
    logic              cyc_q, cyc_d;
    logic              bus_err_q, bus_err_d;

    logic              cnt_clr_s;
    logic              cnt_en_s;
    logic              expire_s;
    logic              bus_drop_s;
    logic              stallreq_s;
    logic [DW-1:0]     cpu_data_s;

    wb_timeout_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (cnt_clr_s),
        .en_i     (cnt_en_s),
        .expire_o (expire_s)
    );

    // Next-state, bus latch and CPU-side combinational outputs.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        sel_d      = sel_q;
        we_d       = we_q;
        cyc_d      = cyc_q;
        rd_buf_d   = rd_buf_q;
        bus_err_d  = 1'b0;
        cnt_clr_s  = 1'b0;
        cnt_en_s   = 1'b0;
        bus_drop_s = 1'b0;
        stallreq_s = 1'b0;
        cpu_data_s = {DW{1'b0}};

        case (state_q)
            WB_IDLE: begin
                if (cpu_ce_i && !flush_i) begin
                    cyc_d      = 1'b1;
                    addr_d     = cpu_addr_i;
                    wdata_d    = cpu_data_i;
                    sel_d      = cpu_sel_i;
                    we_d       = cpu_we_i;
                    cnt_clr_s  = 1'b1;
                    stallreq_s = 1'b1;
                    state_d    = WB_BUSY;
                end else begin
                    state_d    = WB_IDLE;
                end
            end
            WB_BUSY: begin
                // Flush outranks ack and timeout: the instruction is being discarded.
                if (flush_i) begin
                    bus_drop_s = 1'b1;
                    rd_buf_d   = DW'(ZERO_WORD);
                    state_d    = WB_IDLE;
                end else if (wishbone_ack_i) begin
                    bus_drop_s = 1'b1;
                    if (we_q) begin
                        rd_buf_d   = DW'(ZERO_WORD);
                    end else begin
                        rd_buf_d   = wishbone_data_i;
                        cpu_data_s = wishbone_data_i;
                    end
                    if (stall_i != {STALL_W{1'b0}}) begin
                        state_d = WB_WAIT_FOR_STALL;
                    end else begin
                        state_d = WB_IDLE;
                    end
                end else if (expire_s) begin
                    bus_drop_s = 1'b1;
                    bus_err_d  = 1'b1;
                    rd_buf_d   = DW'(ZERO_WORD);
                    state_d    = WB_IDLE;
                end else begin
                    cnt_en_s   = 1'b1;
                    stallreq_s = 1'b1;
                end
            end
            WB_WAIT_FOR_STALL: begin
                cpu_data_s = rd_buf_q;
                if (flush_i) begin
                    rd_buf_d = DW'(ZERO_WORD);
                    state_d  = WB_IDLE;
                end else if (stall_i == {STALL_W{1'b0}}) begin
                    state_d  = WB_IDLE;
                end else begin
                    state_d  = WB_WAIT_FOR_STALL;
                end
            end
            default: begin
                bus_drop_s = 1'b1;
                state_d    = WB_IDLE;
            end
        endcase

        if (bus_drop_s) begin
            cyc_d   = 1'b0;
            we_d    = 1'b0;
            addr_d  = {AW{1'b0}};
            wdata_d = {DW{1'b0}};
            sel_d   = {SW{1'b0}};
        end else begin
            cyc_d   = cyc_d;
        end
    end

    // State, bus and read-buffer registers.
    always_ff @(posedge clk or negedge rst) begin
        if (rst == RST_ENABLE_N) begin
            state_q   <= WB_IDLE;
            addr_q    <= {AW{1'b0}};
            wdata_q   <= {DW{1'b0}};
            sel_q     <= {SW{1'b0}};
            we_q      <= 1'b0;
            cyc_q     <= 1'b0;
            rd_buf_q  <= {DW{1'b0}};
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            sel_q     <= sel_d;
            we_q      <= we_d;
            cyc_q     <= cyc_d;
            rd_buf_q  <= rd_buf_d;
            bus_err_q <= bus_err_d;
        end
    end

    // No stall request while reset is held, even if the CPU still asserts ce.
    assign stallreq_o      = stallreq_s && (rst != RST_ENABLE_N);
    assign cpu_data_o      = cpu_data_s;
    assign bus_err_o       = bus_err_q;
    assign wishbone_addr_o = addr_q;
    assign wishbone_data_o = wdata_q;
    assign wishbone_we_o   = we_q;
    assign wishbone_sel_o  = sel_q;
    assign wishbone_stb_o  = cyc_q;
    assign wishbone_cyc_o  = cyc_q;

endmodule

// File: tb/tb_wb_bus_if.sv
// Directed bench for wb_bus_if: transaction-level model compared every cycle
// plus hand-computed literal expectations at the interesting points.
module tb_wb_bus_if;

    localparam int TB_TIMEOUT = 8;

    logic        clk;
    logic        rst;
    logic [5:0]  stall_i;
    logic        flush_i;
    logic        cpu_ce_i;
    logic        cpu_we_i;
    logic [31:0] cpu_addr_i;
    logic [3:0]  cpu_sel_i;
    logic [31:0] cpu_data_i;
    logic [31:0] cpu_data_o;
    logic        stallreq_o;
    logic        bus_err_o;
    logic [31:0] wishbone_data_i;
    logic        wishbone_ack_i;
    logic [31:0] wishbone_addr_o;
    logic [31:0] wishbone_data_o;
    logic        wishbone_we_o;
    logic [3:0]  wishbone_sel_o;
    logic        wishbone_stb_o;
    logic        wishbone_cyc_o;

    int n_pass  = 0;
    int n_total = 0;
    logic chk_en = 1'b0;

    wb_bus_if #(
        .DW(32), .AW(32), .STALL_W(6), .TIMEOUT(TB_TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
        .cpu_ce_i(cpu_ce_i), .cpu_we_i(cpu_we_i), .cpu_addr_i(cpu_addr_i),
        .cpu_sel_i(cpu_sel_i), .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o),
        .stallreq_o(stallreq_o), .bus_err_o(bus_err_o),
        .wishbone_data_i(wishbone_data_i), .wishbone_ack_i(wishbone_ack_i),
        .wishbone_addr_o(wishbone_addr_o), .wishbone_data_o(wishbone_data_o),
        .wishbone_we_o(wishbone_we_o), .wishbone_sel_o(wishbone_sel_o),
        .wishbone_stb_o(wishbone_stb_o), .wishbone_cyc_o(wishbone_cyc_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Transaction-level model: one request in flight, or one read value held.
    logic        m_act, m_hold, m_err, m_we;
    logic [31:0] m_addr, m_wdata, m_hbuf;
    logic [3:0]  m_sel;
    int          m_wait;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_act <= 1'b0; m_hold <= 1'b0; m_err <= 1'b0; m_we <= 1'b0;
            m_addr <= 32'd0; m_wdata <= 32'd0; m_hbuf <= 32'd0; m_sel <= 4'd0;
            m_wait <= 0;
        end else begin
            m_err <= 1'b0;
            if (m_hold) begin
                if (flush_i || stall_i == 6'd0) m_hold <= 1'b0;
            end else if (m_act) begin
                if (flush_i) begin
                    m_act <= 1'b0;
                end else if (wishbone_ack_i) begin
                    m_act <= 1'b0;
                    if (stall_i != 6'd0) begin
                        m_hold <= 1'b1;
                        m_hbuf <= m_we ? 32'd0 : wishbone_data_i;
                    end
                end else if (m_wait == TB_TIMEOUT - 1) begin
                    m_act <= 1'b0;
                    m_err <= 1'b1;
                end else begin
                    m_wait <= m_wait + 1;
                end
            end else if (cpu_ce_i && !flush_i) begin
                m_act <= 1'b1; m_we <= cpu_we_i; m_addr <= cpu_addr_i;
                m_wdata <= cpu_data_i; m_sel <= cpu_sel_i; m_wait <= 0;
            end
        end
    end

    logic        e_stallreq;
    logic [31:0] e_cpu;
    always_comb begin
        e_stallreq = 1'b0;
        e_cpu      = 32'd0;
        if (!rst) begin
            e_stallreq = 1'b0;
        end else if (m_hold) begin
            e_cpu = m_hbuf;
        end else if (m_act) begin
            if (!flush_i && wishbone_ack_i && !m_we) e_cpu = wishbone_data_i;
            e_stallreq = !flush_i && !wishbone_ack_i && (m_wait != TB_TIMEOUT - 1);
        end else begin
            e_stallreq = cpu_ce_i && !flush_i;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("model_cyc",      32'(wishbone_cyc_o),  32'(m_act));
            chk("model_stb",      32'(wishbone_stb_o),  32'(m_act));
            chk("model_addr",     wishbone_addr_o,      m_act ? m_addr : 32'd0);
            chk("model_wdata",    wishbone_data_o,      m_act ? m_wdata : 32'd0);
            chk("model_we",       32'(wishbone_we_o),   32'(m_act & m_we));
            chk("model_sel",      32'(wishbone_sel_o),  32'(m_act ? m_sel : 4'd0));
            chk("model_bus_err",  32'(bus_err_o),       32'(m_err));
            chk("model_stallreq", 32'(stallreq_o),      32'(e_stallreq));
            chk("model_cpu_data", cpu_data_o,           e_cpu);
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_req(input logic ce, input logic we, input logic [31:0] addr,
                           input logic [3:0] sel, input logic [31:0] data);
        cpu_ce_i = ce; cpu_we_i = we; cpu_addr_i = addr; cpu_sel_i = sel; cpu_data_i = data;
    endtask

    task automatic set_slv(input logic ack, input logic [31:0] rdata);
        wishbone_ack_i = ack; wishbone_data_i = rdata;
    endtask

    initial begin
        int n_cyc;
        rst = 1'b0; stall_i = 6'd0; flush_i = 1'b0;
        set_req(1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
        set_slv(1'b0, 32'd0);
        @(posedge clk);
        chk_en = 1'b1;
        step();
        chk("rst_cyc", 32'(wishbone_cyc_o), 32'd0);
        chk("rst_addr", wishbone_addr_o, 32'd0);
        chk("rst_bus_err", 32'(bus_err_o), 32'd0);
        chk("rst_cpu_data", cpu_data_o, 32'd0);
        rst = 1'b1;
        step();

        // Read, ack on the 3rd busy cycle.
        set_req(1'b1, 1'b0, 32'h0000_0100, 4'hF, 32'd0);
        settle();
        chk("rd_idle_stallreq", 32'(stallreq_o), 32'd1);
        step();
        set_req(1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
        n_cyc = 0;
        for (int i = 0; i < 3; i++) begin
            if (i == 2) set_slv(1'b1, 32'hDEAD_BEEF);
            else        set_slv(1'b0, 32'd0);
            settle();
            if (wishbone_cyc_o) n_cyc++;
            if (i == 2) begin
                chk("rd_ack_data", cpu_data_o, 32'hDEAD_BEEF);
                chk("rd_ack_stallreq", 32'(stallreq_o), 32'd0);
            end else begin
                chk("rd_busy_stallreq", 32'(stallreq_o), 32'd1);
            end
            step();
        end
        set_slv(1'b0, 32'd0);
        settle();
        chk("rd_cyc_after", 32'(wishbone_cyc_o), 32'd0);
        chk("rd_cyc_count", 32'(n_cyc), 32'd3);

        // Write, ack on the 1st busy cycle; CPU inputs change meanwhile.
        set_req(1'b1, 1'b1, 32'h0000_0204, 4'b0011, 32'h1234_5678);
        settle();
        step();
        set_req(1'b0, 1'b0, 32'hFFFF_FFFF, 4'hF, 32'hFFFF_FFFF);
        set_slv(1'b1, 32'hA5A5_A5A5);
        settle();
        chk("wr_addr", wishbone_addr_o, 32'h0000_0204);
        chk("wr_data", wishbone_data_o, 32'h1234_5678);
        chk("wr_sel", 32'(wishbone_sel_o), 32'h3);
        chk("wr_we", 32'(wishbone_we_o), 32'd1);
        chk("wr_cpu_data", cpu_data_o, 32'd0);
        step();
        set_slv(1'b0, 32'd0);
        settle();
        chk("wr_cyc_after", 32'(wishbone_cyc_o), 32'd0);
        chk("wr_sel_after", 32'(wishbone_sel_o), 32'd0);

        // Read acked while the pipeline is stalled elsewhere.
        set_req(1'b1, 1'b0, 32'h0000_0300, 4'hF, 32'd0);
        settle();
        step();
        set_req(1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
        set_slv(1'b1, 32'hCAFE_F00D);
        stall_i = 6'b000111;
        settle();
        chk("hold_ack_data", cpu_data_o, 32'hCAFE_F00D);
        step();
        set_slv(1'b0, 32'h0BAD_BEEF);
        for (int i = 0; i < 4; i++) begin
            settle();
            chk("hold_data", cpu_data_o, 32'hCAFE_F00D);
            chk("hold_stallreq", 32'(stallreq_o), 32'd0);
            step();
        end
        stall_i = 6'd0;
        settle();
        chk("hold_last_data", cpu_data_o, 32'hCAFE_F00D);
        step();
        settle();
        chk("hold_released", cpu_data_o, 32'd0);

        // Flush in the 2nd busy cycle together with ack.
        set_req(1'b1, 1'b0, 32'h0000_0400, 4'hF, 32'd0);
        settle();
        step();
        set_req(1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
        settle();
        chk("fl_busy_stallreq", 32'(stallreq_o), 32'd1);
        step();
        set_slv(1'b1, 32'h55AA_55AA);
        flush_i = 1'b1;
        settle();
        chk("fl_cpu_data", cpu_data_o, 32'd0);
        chk("fl_stallreq", 32'(stallreq_o), 32'd0);
        step();
        flush_i = 1'b0;
        set_slv(1'b0, 32'd0);
        settle();
        chk("fl_cyc_after", 32'(wishbone_cyc_o), 32'd0);
        chk("fl_cpu_data_after", cpu_data_o, 32'd0);

        // Slave never acks: abort after TB_TIMEOUT busy cycles.
        set_req(1'b1, 1'b0, 32'h0000_0500, 4'hF, 32'd0);
        settle();
        step();
        set_req(1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
        n_cyc = 0;
        for (int k = 0; k < 20; k++) begin
            settle();
            if (!wishbone_cyc_o) break;
            n_cyc++;
            if (n_cyc == 8) chk("to_abort_stallreq", 32'(stallreq_o), 32'd0);
            step();
        end
        chk("to_busy_cycles", 32'(n_cyc), 32'd8);
        chk("to_bus_err", 32'(bus_err_o), 32'd1);
        step();
        settle();
        chk("to_bus_err_pulse", 32'(bus_err_o), 32'd0);

        // Asynchronous reset between edges while busy.
        set_req(1'b1, 1'b0, 32'h0000_0600, 4'hF, 32'd0);
        settle();
        step();
        settle();
        chk("ar_cyc_before", 32'(wishbone_cyc_o), 32'd1);
        #2;
        rst = 1'b0;
        #1;
        chk("ar_cyc", 32'(wishbone_cyc_o), 32'd0);
        chk("ar_stb", 32'(wishbone_stb_o), 32'd0);
        chk("ar_addr", wishbone_addr_o, 32'd0);
        chk("ar_stallreq", 32'(stallreq_o), 32'd0);
        set_req(1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
        @(negedge clk);
        #1;
        rst = 1'b1;
        step();
        settle();
        chk("ar_idle_cyc", 32'(wishbone_cyc_o), 32'd0);

        // Back-to-back: ce held through the ack starts a new transaction next edge.
        set_req(1'b1, 1'b0, 32'h0000_0700, 4'hF, 32'd0);
        settle();
        step();
        set_slv(1'b1, 32'h1111_2222);
        settle();
        chk("b2b_ack_data", cpu_data_o, 32'h1111_2222);
        step();
        set_slv(1'b0, 32'd0);
        settle();
        chk("b2b_gap_cyc", 32'(wishbone_cyc_o), 32'd0);
        chk("b2b_gap_stallreq", 32'(stallreq_o), 32'd1);
        step();
        settle();
        chk("b2b_restart_cyc", 32'(wishbone_cyc_o), 32'd1);
        chk("b2b_restart_addr", wishbone_addr_o, 32'h0000_0700);
        set_req(1'b0, 1'b0, 32'd0, 4'd0, 32'd0);
        set_slv(1'b1, 32'h3333_4444);
        step();
        set_slv(1'b0, 32'd0);
        settle();
        chk("b2b_done_cyc", 32'(wishbone_cyc_o), 32'd0);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/wb_bus_if.md
Name: wb_bus_if

Overview:
- Wishbone B3 classic master bridge between the CPU core's simple memory/instruction-fetch port and the Wishbone interconnect.
- One instance serves the data path and one serves the instruction path. Each replaces the direct CPU-to-ram/rom wiring in the minimal SOPC.
- Converts single-cycle ce/we/sel requests into multi-cycle Wishbone transactions.
- Raises a pipeline stall request until the slave acks, then holds read data stable while the pipeline remains stalled by other causes.

Parameters:
- DW, 32, data bus width.
- AW, 32, address bus width.
- STALL_W, 6, width of the pipeline stall vector from ctrl.
- TIMEOUT, 255, max cycles waiting for ack before abort; 0 disables the timeout.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-low (0 = reset asserted).
- stall_i  in  STALL_W  pipeline stall vector from ctrl.
- flush_i  in  1  pipeline flush (exception).
- cpu_ce_i  in  1  CPU request valid.
- cpu_we_i  in  1  1 = write, 0 = read.
- cpu_addr_i  in  AW  request address.
- cpu_sel_i  in  DW/8  byte lane select.
- cpu_data_i  in  DW  write data.
- cpu_data_o  out  DW  read data to CPU.
- stallreq_o  out  1  stall request to ctrl.
- bus_err_o  out  1  one-cycle pulse on timeout abort.
- wishbone_data_i  in  DW  slave read data.
- wishbone_ack_i  in  1  slave acknowledge.
- wishbone_addr_o  out  AW  bus address.
- wishbone_data_o  out  DW  bus write data.
- wishbone_we_o  out  1  bus write enable.
- wishbone_sel_o  out  DW/8  bus byte select.
- wishbone_stb_o  out  1  strobe.
- wishbone_cyc_o  out  1  cycle valid.

Behaviour:
- Reset (rst=0, async):
  - state=IDLE.
  - All wishbone_* outputs 0.
  - rd_buf=0, timeout counter=0, bus_err_o=0.
- Registered outputs: wishbone_*, bus_err_o, rd_buf, state, counter.
- Combinational outputs: stallreq_o, cpu_data_o.
- IDLE:
  - If cpu_ce_i && !flush_i, on the next edge: cyc=stb=1; addr/data/we/sel latched from cpu_*; counter cleared; go to BUSY.
  - Comb: stallreq_o=1 when cpu_ce_i && !flush_i, else 0. cpu_data_o=0.
- BUSY (cyc=stb=1, address/data/sel/we held constant):
  - flush_i=1 (priority over ack and timeout): next edge cyc=stb=we=0, addr/data/sel=0, rd_buf=0, go to IDLE. Comb: stallreq_o=0, cpu_data_o=0.
  - ack_i=1: next edge cyc=stb=we=0, addr/data/sel=0. If the transaction was a read, rd_buf=wishbone_data_i, else rd_buf=0. Go to WAIT_FOR_STALL if stall_i!=0, else IDLE. Comb same cycle: stallreq_o=0, cpu_data_o=wishbone_data_i for a read, 0 for a write.
  - No ack: counter increments; stallreq_o=1, cpu_data_o=0.
  - TIMEOUT!=0 and counter==TIMEOUT-1 without ack: next edge abort as for flush, bus_err_o=1 for one cycle, rd_buf=0, go to IDLE. stallreq_o drops in the abort cycle.
- WAIT_FOR_STALL: stallreq_o=0, cpu_data_o=rd_buf. Go to IDLE on the edge where stall_i==0. Incoming flush_i also forces IDLE with rd_buf=0.
- Transaction issue rate: no new transaction is issued on the IDLE exit edge; minimum two cycles per transaction (request→ack).
- Back-to-back: after returning to IDLE, a still-asserted cpu_ce_i starts a new transaction the next edge.
- Counter is 16 bits and saturates; TIMEOUT must be < 65536.
- Reset mid-transaction drops cyc/stb immediately (async), per Wishbone RST semantics.

Decomposition:
- Shared defines (defines.v): state encodings WB_IDLE=2'b00, WB_BUSY=2'b01, WB_WAIT_FOR_STALL=2'b10; ZeroWord; reset-asserted level constant RstEnable_n=1'b0.
- The timeout counter is a natural sub-module: wb_timeout_cnt (clear, enable, expire flag).

Test Plan:
- Read, ack after 3 cycles: cpu_ce=1, we=0, addr=0x100, slave returns 0xDEADBEEF. Expect cyc/stb high for 3 cycles, stallreq=1 until the ack cycle, cpu_data_o=0xDEADBEEF in the ack cycle, cyc=0 next cycle.
- Write with sel=4'b0011, data=0x12345678, addr=0x204, ack after 1 cycle. Expect bus outputs held exactly until ack, cpu_data_o=0 throughout, state returns to IDLE.
- Read acked while stall_i=6'b000111 held for 4 more cycles. Expect WAIT_FOR_STALL, cpu_data_o stable at the read value, stallreq=0, IDLE after stall_i=0.
- flush_i pulsed in the 2nd BUSY cycle with ack arriving the same cycle. Expect abort: cyc=stb=0 next edge, cpu_data_o=0, no rd_buf update.
- TIMEOUT=8 with slave never acking. Expect cyc deasserted after 8 BUSY cycles, single-cycle bus_err_o pulse, IDLE.
- rst driven low asynchronously mid-BUSY (between clock edges). Expect all wishbone_* outputs and stallreq_o at 0 immediately, IDLE after release.
